// File: rtl/csla_pkg.sv
// Shared helpers for the carry-select adder family: stage count and width legality.
package csla_pkg;

    function automatic int unsigned csla_nstg(input int unsigned width, input int unsigned block);
        return (block == 0) ? 1 : width / block;
    endfunction

    function automatic bit csla_width_ok(input int unsigned width, input int unsigned block);
        return (block != 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/csla_slice.sv
// One carry-select slice: two ripple sums (carry-in 0 and 1) muxed on the incoming carry.
module csla_slice #(
    parameter int unsigned BLOCK = 16
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_sel,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] sum0, sum1;
    logic             co0, co1, msb0, msb1;
    logic             k0, k1;

    always_comb begin
        sum0 = '0;
        sum1 = '0;
        msb0 = 1'b0;
        msb1 = 1'b0;
        k0   = 1'b0;
        k1   = 1'b1;
        for (int i = 0; i < int'(BLOCK); i++) begin
            // Carry into the top bit feeds the signed-overflow detector.
            if (i == int'(BLOCK) - 1) begin
                msb0 = k0;
                msb1 = k1;
            end
            sum0[i] = a[i] ^ b[i] ^ k0;
            sum1[i] = a[i] ^ b[i] ^ k1;
            k0 = (a[i] & b[i]) | (k0 & (a[i] ^ b[i]));
            k1 = (a[i] & b[i]) | (k1 & (a[i] ^ b[i]));
        end
        co0 = k0;
        co1 = k1;
    end

    assign sum      = c_sel ? sum1 : sum0;
    assign cout     = c_sel ? co1  : co0;
    assign c_msb_in = c_sel ? msb1 : msb0;

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor: one slice per stage, carry ripples one stage per cycle.
module csla_pipe
    import csla_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLOCK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = csla_nstg(WIDTH, BLOCK);

    if (!csla_width_ok(WIDTH, BLOCK)) begin : g_width_chk
        $error("csla_pipe: WIDTH must be a nonzero multiple of BLOCK");
    end

    logic                       en;
    logic [NSTG-1:0]            valid_q, carry_q, cmsb_q;
    logic [NSTG-1:0]            stg_v, stg_c, slice_cout, slice_cmsb;
    logic [NSTG-1:0][WIDTH-1:0] opa_q, opb_q, sum_q;
    logic [NSTG-1:0][WIDTH-1:0] stg_a, stg_b, stg_sum, nxt_sum;
    logic [NSTG-1:0][BLOCK-1:0] slice_sum;

    // Whole pipe advances together; it only holds when the output is blocked.
    assign en       = !(valid_q[NSTG-1] && !out_ready);
    assign in_ready = en;

    // Stage inputs: stage 0 takes the ports, stage k takes stage k-1's registers.
    always_comb begin
        stg_v      = '0;
        stg_c      = '0;
        stg_a      = '0;
        stg_b      = '0;
        stg_sum    = '0;
        stg_v[0]   = in_valid;
        stg_a[0]   = a;
        stg_b[0]   = sub ? ~b : b;
        stg_c[0]   = sub | cin;
        for (int k = 1; k < int'(NSTG); k++) begin
            stg_v[k]   = valid_q[k-1];
            stg_a[k]   = opa_q[k-1];
            stg_b[k]   = opb_q[k-1];
            stg_c[k]   = carry_q[k-1];
            stg_sum[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_slice
        csla_slice #(
            .BLOCK(BLOCK)
        ) u_slice (
            .a        (stg_a[k][k*BLOCK +: BLOCK]),
            .b        (stg_b[k][k*BLOCK +: BLOCK]),
            .c_sel    (stg_c[k]),
            .sum      (slice_sum[k]),
            .cout     (slice_cout[k]),
            .c_msb_in (slice_cmsb[k])
        );
    end

    always_comb begin
        nxt_sum = stg_sum;
        for (int k = 0; k < int'(NSTG); k++) begin
            nxt_sum[k][k*BLOCK +: BLOCK] = slice_sum[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
        end else if (en) begin
            valid_q <= stg_v;
            carry_q <= slice_cout;
            cmsb_q  <= slice_cmsb;
            opa_q   <= stg_a;
            opb_q   <= stg_b;
            sum_q   <= nxt_sum;
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign sum       = sum_q[NSTG-1];
    assign cout      = carry_q[NSTG-1];
    assign ovf       = cmsb_q[NSTG-1] ^ carry_q[NSTG-1];

    // Last-stage operand copies and early-stage MSB carries have no consumer.
    logic unused_regs;
    assign unused_regs = ^{opa_q[NSTG-1], opb_q[NSTG-1], cmsb_q};

endmodule

// File: tb/tb_csla_pipe.sv
// Directed bench for csla_pipe (WIDTH=64, BLOCK=16): hand vectors plus a model-backed output queue.
module tb_csla_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    logic [65:0] exp_q[$];

    csla_pipe #(
        .WIDTH(64),
        .BLOCK(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mcin, input logic msub);
        logic [63:0] bb;
        logic [64:0] r;
        logic        v;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {64'd0, (msub | mcin)};
        v  = (ma[63] == bb[63]) && (r[63] != ma[63]);
        return {v, r};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one operation and returns just after the edge that accepts it.
    task automatic send(input logic [63:0] sa, input logic [63:0] sb,
                        input logic scin, input logic ssub);
        logic rdy;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        a        = sa;
        b        = sb;
        cin      = scin;
        sub      = ssub;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back(model(sa, sb, scin, ssub));
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 66'd1, 66'd0);
        in_valid = 1'b0;
    endtask

    // Waits for the next result and checks latency and value against hand-computed constants.
    task automatic expect_next(input string tag, input logic [63:0] es, input logic ec,
                               input logic eo, input int elat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid) lat = n;
        end
        chk({tag, "_latency"}, 66'(lat), 66'(elat));
        chk({tag, "_sum"}, {2'b00, sum}, {2'b00, es});
        chk({tag, "_cout"}, {65'd0, cout}, {65'd0, ec});
        chk({tag, "_ovf"}, {65'd0, ovf}, {65'd0, eo});
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every transfer must match the model queue in order; stalls must hold the head.
    always @(negedge clk) begin
        if (out_valid) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_bad++;
                $error("FAIL spurious_out: observed sum %0h expected no result", sum);
            end
            if (exp_q.size() != 0) begin
                if (out_ready) begin
                    chk("mon_result", {ovf, cout, sum}, exp_q.pop_front());
                    n_out++;
                end else begin
                    chk("mon_held", {ovf, cout, sum}, exp_q[0]);
                end
            end
        end
    end

    logic [63:0] tab_a[8];
    logic [63:0] tab_b[8];
    logic        tab_c[8];
    logic        tab_s[8];
    int          out_base;
    int          seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        tab_a = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 64'd100,
                  64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
        tab_b = '{64'd2, 64'd1, 64'h0000_0001_0000_0001, 64'd300,
                  64'd1, 64'h0FED_CBA9_8765_4321, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        tab_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        #1;
        chk("reset_out_valid", {65'd0, out_valid}, 66'd0);
        chk("reset_sum", {2'b00, sum}, 66'd0);
        chk("reset_cout_ovf", {64'd0, cout, ovf}, 66'd0);
        chk("reset_in_ready", {65'd0, in_ready}, 66'd1);

        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(64'd10, 64'd35, 1'b0, 1'b0);
        expect_next("t1", 64'd45, 1'b0, 1'b0, 4);

        send(64'd866945, 64'd3324752, 1'b1, 1'b0);
        expect_next("t2", 64'd4191698, 1'b0, 1'b0, 4);

        send(64'd6223372036854775808, 64'd38701384792384, 1'b1, 1'b0);
        expect_next("t3", 64'd6223410738239568193, 1'b0, 1'b0, 4);

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        expect_next("t4_carry_chain", 64'd0, 1'b1, 1'b0, 4);

        send(64'd5, 64'd7, 1'b0, 1'b1);
        expect_next("t5_sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4);

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        expect_next("t5_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4);

        // Backpressure: 8 back-to-back ops, consumer stalls 3 cycles once the pipe is full.
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(tab_a[i], tab_b[i], tab_c[i], tab_s[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready_low", {65'd0, in_ready}, 66'd0);
                chk("bp_out_valid_high", {65'd0, out_valid}, 66'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
        chk("bp_results_delivered", 66'(n_out - out_base), 66'd8);
        chk("bp_queue_empty", 66'(exp_q.size()), 66'd0);
        @(posedge clk);
        #1;

        // Reset with three operations in flight.
        send(64'd11, 64'd22, 1'b0, 1'b0);
        send(64'd33, 64'd44, 1'b0, 1'b0);
        send(64'd55, 64'd66, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_out_valid", {65'd0, out_valid}, 66'd0);
        chk("rst_mid_sum", {2'b00, sum}, 66'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_stale", 66'(seen), 66'd0);
        @(posedge clk);
        #1;
        send(64'd1000, 64'd2345, 1'b1, 1'b0);
        expect_next("rst_after", 64'd3346, 1'b0, 1'b0, 4);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 66'(exp_q.size()), 66'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
